// File: rtl/id_operand_stage.sv
// id_operand_stage: IF/ID pipeline register, instruction-word buffer for
// stalls, rs/rt operand resolution with prioritised forwarding, and the
// load-use interlock request with a saturating consecutive-stall counter.
module id_operand_stage #(
  parameter int DATA_W       = 32,
  parameter int NUM_FWD      = 3,
  parameter int LOAD_UNREADY = 1,
  parameter int CNT_W        = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [5:0]                i_stall,
  input  logic                      i_if_ce,
  input  logic [DATA_W-1:0]         i_if_pc,
  input  logic [DATA_W-1:0]         i_inst_sram_rdata,
  input  logic                      i_use_rs,
  input  logic                      i_use_rt,
  output logic [4:0]                o_rf_raddr1,
  output logic [4:0]                o_rf_raddr2,
  input  logic [DATA_W-1:0]         i_rf_rdata1,
  input  logic [DATA_W-1:0]         i_rf_rdata2,
  input  logic [NUM_FWD-1:0]        i_fwd_we,
  input  logic [5*NUM_FWD-1:0]      i_fwd_waddr,
  input  logic [DATA_W*NUM_FWD-1:0] i_fwd_wdata,
  input  logic [NUM_FWD-1:0]        i_fwd_is_load,
  output logic                      o_id_valid,
  output logic [DATA_W-1:0]         o_id_pc,
  output logic [DATA_W-1:0]         o_id_inst,
  output logic [DATA_W-1:0]         o_op1,
  output logic [DATA_W-1:0]         o_op2,
  output logic                      o_stallreq,
  output logic [CNT_W-1:0]          o_stall_cnt
);

  logic              r_id_valid;
  logic [DATA_W-1:0] r_id_pc;
  logic [DATA_W-1:0] r_inst_buf;
  logic              r_hold;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_if_stop;
  logic              w_id_stop;
  logic              w_bubble;
  logic              w_hold_both;
  logic [DATA_W-1:0] w_id_inst;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;
  logic              w_hz1;
  logic              w_hz2;
  logic              w_stallreq;
  logic              w_stall_unused;

  assign w_if_stop   = i_stall[1];
  assign w_id_stop   = i_stall[2];
  assign w_bubble    = w_if_stop & ~w_id_stop;
  assign w_hold_both = w_if_stop & w_id_stop;

  // Only the IF/ID and ID/EX stop bits matter here.
  assign w_stall_unused = ^{i_stall[5:3], i_stall[0]};

  // IF/ID register: bubble when IF stops but ID drains, load when IF moves.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= '0;
    end else if (w_bubble) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= '0;
    end else if (!w_if_stop) begin
      r_id_valid <= i_if_ce;
      r_id_pc    <= i_if_pc;
    end
  end

  // The SRAM word is only presented for one cycle, so capture it on the
  // first held cycle and keep it until ID moves or a bubble is inserted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inst_buf <= '0;
      r_hold     <= 1'b0;
    end else if (w_hold_both) begin
      if (!r_hold) begin
        r_inst_buf <= i_inst_sram_rdata;
        r_hold     <= 1'b1;
      end
    end else begin
      r_hold <= 1'b0;
    end
  end

  assign w_id_inst = !r_id_valid ? '0 :
                     r_hold      ? r_inst_buf : i_inst_sram_rdata;
  assign w_rs      = w_id_inst[25:21];
  assign w_rt      = w_id_inst[20:16];

  // Operand resolution: scan oldest to youngest so the lowest matching index
  // wins; only that winner decides whether a load-use hazard exists.
  always_comb begin
    w_op1 = i_rf_rdata1;
    w_op2 = i_rf_rdata2;
    w_hz1 = 1'b0;
    w_hz2 = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (i_fwd_we[i] && (i_fwd_waddr[5*i +: 5] == w_rs)) begin
        w_op1 = i_fwd_wdata[DATA_W*i +: DATA_W];
        w_hz1 = (i < LOAD_UNREADY) && i_fwd_is_load[i];
      end
      if (i_fwd_we[i] && (i_fwd_waddr[5*i +: 5] == w_rt)) begin
        w_op2 = i_fwd_wdata[DATA_W*i +: DATA_W];
        w_hz2 = (i < LOAD_UNREADY) && i_fwd_is_load[i];
      end
    end
    if (w_rs == 5'd0) begin
      w_op1 = '0;
      w_hz1 = 1'b0;
    end
    if (w_rt == 5'd0) begin
      w_op2 = '0;
      w_hz2 = 1'b0;
    end
  end

  assign w_stallreq = r_id_valid & ((i_use_rs & w_hz1) | (i_use_rt & w_hz2));

  // Consecutive interlock cycles, saturating; any free cycle restarts it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
    end else if (w_stallreq) begin
      if (r_stall_cnt != {CNT_W{1'b1}}) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end else begin
      r_stall_cnt <= '0;
    end
  end

  assign o_rf_raddr1 = w_rs;
  assign o_rf_raddr2 = w_rt;
  assign o_id_valid  = r_id_valid;
  assign o_id_pc     = r_id_pc;
  assign o_id_inst   = w_id_inst;
  assign o_op1       = w_op1;
  assign o_op2       = w_op2;
  assign o_stallreq  = w_stallreq;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage (DATA_W=32, NUM_FWD=3, LOAD_UNREADY=1,
// CNT_W=2).
module tb_id_operand_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        if_ce;
  logic [31:0] if_pc;
  logic [31:0] sram;
  logic        use_rs;
  logic        use_rt;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [2:0]  fwd_we;
  logic [14:0] fwd_waddr;
  logic [95:0] fwd_wdata;
  logic [2:0]  fwd_load;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        stallreq;
  logic [1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  // Register file model: each register reads back a tag plus its index.
  assign rdata1 = 32'hA000_0000 | {27'd0, raddr1};
  assign rdata2 = 32'hB000_0000 | {27'd0, raddr2};

  id_operand_stage #(.DATA_W(32), .NUM_FWD(3), .LOAD_UNREADY(1), .CNT_W(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_if_ce(if_ce), .i_if_pc(if_pc),
    .i_inst_sram_rdata(sram), .i_use_rs(use_rs), .i_use_rt(use_rt),
    .o_rf_raddr1(raddr1), .o_rf_raddr2(raddr2),
    .i_rf_rdata1(rdata1), .i_rf_rdata2(rdata2),
    .i_fwd_we(fwd_we), .i_fwd_waddr(fwd_waddr), .i_fwd_wdata(fwd_wdata),
    .i_fwd_is_load(fwd_load),
    .o_id_valid(id_valid), .o_id_pc(id_pc), .o_id_inst(id_inst),
    .o_op1(op1), .o_op2(op2), .o_stallreq(stallreq), .o_stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_fwd();
    fwd_we    = '0;
    fwd_waddr = '0;
    fwd_wdata = '0;
    fwd_load  = '0;
  endtask

  task automatic set_fwd(input int idx, input logic we, input logic [4:0] addr,
                         input logic [31:0] data, input logic ld);
    fwd_we[idx]            = we;
    fwd_waddr[5*idx +: 5]  = addr;
    fwd_wdata[32*idx +: 32] = data;
    fwd_load[idx]          = ld;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = '0; if_ce = 1'b1; if_pc = 32'h1234_5678;
    sram = 32'h00A8_0000; use_rs = 1'b1; use_rt = 1'b1;
    clear_fwd();
    set_fwd(0, 1'b1, 5'd0, 32'hFF, 1'b1);
    next_cycle();
    next_cycle();
    #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", id_valid); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", id_pc); end
    checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", id_inst); end
    checks++; if (op1 !== 32'h0 || op2 !== 32'h0) begin errors++; $display("FAIL reset_ops got %h/%h exp 0/0", op1, op2); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL reset_stallreq got %h exp 0", stallreq); end
    checks++; if (stall_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_fetch();
    clear_fwd(); use_rs = 1'b0; use_rt = 1'b0;
    rst = 1'b0; if_ce = 1'b1; if_pc = 32'hBFC0_0000; sram = 32'h3C01_1234;
    next_cycle();
    #1;
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid got %h exp 1", id_valid); end
    checks++; if (id_pc !== 32'hBFC0_0000) begin errors++; $display("FAIL fetch_pc got %h exp bfc00000", id_pc); end
    checks++; if (id_inst !== 32'h3C01_1234) begin errors++; $display("FAIL fetch_inst got %h exp 3c011234", id_inst); end
    checks++; if (op2 !== 32'hB000_0001) begin errors++; $display("FAIL fetch_op2 got %h exp b0000001", op2); end
  endtask

  task automatic test_hold();
    stall = 6'b000111;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      sram = 32'hDEAD_BEEF;
      #1;
      checks++; if (id_inst !== 32'h3C01_1234) begin errors++; $display("FAIL hold_inst[%0d] got %h exp 3c011234", k, id_inst); end
      checks++; if (id_pc !== 32'hBFC0_0000 || id_valid !== 1'b1) begin errors++; $display("FAIL hold_pc[%0d] got %h/%h exp bfc00000/1", k, id_pc, id_valid); end
    end
    stall = 6'b0; if_pc = 32'hBFC0_0004;
    next_cycle();
    #1;
    checks++; if (id_inst !== 32'hDEAD_BEEF) begin errors++; $display("FAIL release_inst got %h exp deadbeef", id_inst); end
    checks++; if (id_pc !== 32'hBFC0_0004) begin errors++; $display("FAIL release_pc got %h exp bfc00004", id_pc); end
  endtask

  task automatic test_fwd_priority();
    sram = 32'h00A8_0000;  // rs=5, rt=8
    clear_fwd();
    set_fwd(0, 1'b1, 5'd5, 32'h11, 1'b0);
    set_fwd(1, 1'b0, 5'd5, 32'h22, 1'b0);
    set_fwd(2, 1'b1, 5'd5, 32'h33, 1'b0);
    #1;
    checks++; if (op1 !== 32'h11) begin errors++; $display("FAIL fwd_youngest got %h exp 11", op1); end
    checks++; if (op2 !== 32'hB000_0008) begin errors++; $display("FAIL fwd_rt_rf got %h exp b0000008", op2); end
    fwd_we = 3'b100;
    #1;
    checks++; if (op1 !== 32'h33) begin errors++; $display("FAIL fwd_oldest got %h exp 33", op1); end
    fwd_we = 3'b010;  // disabled source 1 must not win; now enabled
    #1;
    checks++; if (op1 !== 32'h22) begin errors++; $display("FAIL fwd_mid got %h exp 22", op1); end
    fwd_we = 3'b000;
    #1;
    checks++; if (op1 !== 32'hA000_0005) begin errors++; $display("FAIL fwd_none got %h exp a0000005", op1); end
    next_cycle();
    sram = 32'h0008_0000;  // rs=0, rt=8
    clear_fwd();
    set_fwd(0, 1'b1, 5'd0, 32'hFF, 1'b0);
    #1;
    checks++; if (op1 !== 32'h0) begin errors++; $display("FAIL fwd_r0 got %h exp 0", op1); end
  endtask

  task automatic test_load_use();
    next_cycle();
    sram = 32'h00A8_0000;
    clear_fwd();
    set_fwd(0, 1'b1, 5'd8, 32'h44, 1'b1);
    use_rs = 1'b0; use_rt = 1'b1;
    #1;
    checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL lu_rt got %h exp 1", stallreq); end
    checks++; if (op2 !== 32'h44) begin errors++; $display("FAIL lu_rt_op2 got %h exp 44", op2); end
    use_rt = 1'b0;
    #1;
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL lu_unused got %h exp 0", stallreq); end
    next_cycle();
    clear_fwd();
    set_fwd(1, 1'b1, 5'd8, 32'h55, 1'b1);
    use_rt = 1'b1;
    #1;
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL lu_idx1 got %h exp 0", stallreq); end
    checks++; if (op2 !== 32'h55) begin errors++; $display("FAIL lu_idx1_op2 got %h exp 55", op2); end
    next_cycle();
    clear_fwd();
    set_fwd(0, 1'b1, 5'd5, 32'h66, 1'b1);
    use_rs = 1'b1; use_rt = 1'b0;
    #1;
    checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL lu_rs got %h exp 1", stallreq); end
    next_cycle();
    sram = 32'h0008_0000;  // rs=0: load targeting r0 is not a hazard
    set_fwd(0, 1'b1, 5'd0, 32'h66, 1'b1);
    #1;
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL lu_r0 got %h exp 0", stallreq); end
    clear_fwd(); use_rs = 1'b0; use_rt = 1'b0;
  endtask

  task automatic test_bubble();
    next_cycle();
    sram = 32'h00A8_0000; stall = 6'b000111;
    next_cycle();
    stall = 6'b000011;
    set_fwd(0, 1'b1, 5'd8, 32'h77, 1'b1);
    use_rt = 1'b1;
    next_cycle();
    #1;
    checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0) begin errors++; $display("FAIL bubble_valid got %h/%h exp 0/0", id_valid, id_pc); end
    checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL bubble_inst got %h exp 0", id_inst); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL bubble_stallreq got %h exp 0", stallreq); end
    stall = 6'b0; if_pc = 32'hBFC0_0010; sram = 32'h00A9_0000;  // rt=9
    next_cycle();
    #1;
    checks++; if (id_valid !== 1'b1 || id_inst !== 32'h00A9_0000) begin errors++; $display("FAIL after_bubble got %h/%h exp 1/00a90000", id_valid, id_inst); end
    checks++; if (id_pc !== 32'hBFC0_0010) begin errors++; $display("FAIL after_bubble_pc got %h exp bfc00010", id_pc); end
    clear_fwd(); use_rt = 1'b0;
  endtask

  task automatic test_stall_cnt();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    sram = 32'h00A8_0000; stall = 6'b0; if_ce = 1'b1;
    next_cycle();
    #1;
    checks++; if (stall_cnt !== 2'd0) begin errors++; $display("FAIL cnt_start got %0d exp 0", stall_cnt); end
    set_fwd(0, 1'b1, 5'd8, 32'h88, 1'b1);
    use_rt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      #1;
      checks++; if (stall_cnt !== exp_cnt[k]) begin errors++; $display("FAIL cnt[%0d] got %0d exp %0d", k, stall_cnt, exp_cnt[k]); end
    end
    use_rt = 1'b0;
    next_cycle();
    #1;
    checks++; if (stall_cnt !== 2'd0) begin errors++; $display("FAIL cnt_clear got %0d exp 0", stall_cnt); end
    use_rt = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    checks++; if (stall_cnt !== 2'd2) begin errors++; $display("FAIL cnt_restart got %0d exp 2", stall_cnt); end
    rst = 1'b1;
    next_cycle();
    #1;
    checks++; if (stall_cnt !== 2'd0 || id_valid !== 1'b0) begin errors++; $display("FAIL cnt_rst got %0d/%h exp 0/0", stall_cnt, id_valid); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL cnt_rst_req got %h exp 0", stallreq); end
    rst = 1'b0; clear_fwd(); use_rt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_hold();
    test_fwd_priority();
    test_load_use();
    test_bubble();
    test_stall_cnt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
